// File: rtl/adf4159_ctrl_top.sv
`default_nettype none
// ============================================================================
// Module   : adf4159_ctrl_top
// Brief    : SPI-slave command front end for six ADF4159 synthesizers plus an
//            LO preset port. Frequency commands become R1/R0 3-wire writes;
//            LO presets are applied on trigger edges; status goes out on MISO.
// Revision : 1.0  initial release
// ============================================================================
module adf4159_ctrl_top #(
  parameter int SCLK_HALF = 2,
  parameter int NUM_PLL   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_clk,
  input  logic               spi_cs,
  input  logic               spi_mosi,
  output logic               spi_miso,
  output logic [NUM_PLL-1:0] adf4159_clk,
  output logic [NUM_PLL-1:0] adf4159_data,
  output logic [NUM_PLL-1:0] adf4159_le,
  input  logic [NUM_PLL-1:0] pll_lock,
  input  logic               freq_trig1,
  input  logic               freq_trig2,
  output logic [7:0]         fs,
  output logic [7:0]         vctrl
);

  localparam int             CW       = $clog2(2 * SCLK_HALF);
  localparam logic [CW-1:0]  CNT_LAST = CW'(2 * SCLK_HALF - 1);
  localparam logic [CW-1:0]  CNT_HALF = CW'(SCLK_HALF);
  localparam int             SW       = NUM_PLL + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_R1, S_LOAD_R0, S_SHIFT, S_LATCH, S_GAP
  } state_t;

  // ---------------- synchronizers and edge detection -----------------------
  logic [2:0]         sclk_sync, cs_sync, trig1_sync, trig2_sync;
  logic [1:0]         mosi_sync;
  logic [NUM_PLL-1:0] lock_m, lock_s;

  // Two flops for metastability, a third to detect edges; SPI lines idle high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync  <= 3'b111;
      cs_sync    <= 3'b111;
      mosi_sync  <= 2'b00;
      trig1_sync <= 3'b000;
      trig2_sync <= 3'b000;
      lock_m     <= '0;
      lock_s     <= '0;
    end else begin
      sclk_sync  <= {sclk_sync[1:0], spi_clk};
      cs_sync    <= {cs_sync[1:0], spi_cs};
      mosi_sync  <= {mosi_sync[0], spi_mosi};
      trig1_sync <= {trig1_sync[1:0], freq_trig1};
      trig2_sync <= {trig2_sync[1:0], freq_trig2};
      lock_m     <= pll_lock;
      lock_s     <= lock_m;
    end
  end

  logic sclk_rise, sclk_fall, cs_low, cs_fall, cs_rise, t1_rise, t2_rise;
  assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
  assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
  assign cs_low    = ~cs_sync[1];
  assign cs_fall   = ~cs_sync[1] & cs_sync[2];
  assign cs_rise   = cs_sync[1] & ~cs_sync[2];
  assign t1_rise   = trig1_sync[1] & ~trig1_sync[2];
  assign t2_rise   = trig2_sync[1] & ~trig2_sync[2];

  // ---------------- frame capture -------------------------------------------
  logic [49:0] frame;
  logic [5:0]  bit_cnt;

  // LSB-first shift: the first bit received ends up in frame[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame   <= '0;
      bit_cnt <= '0;
    end else if (cs_fall) begin
      bit_cnt <= '0;
    end else if (sclk_rise && cs_low) begin
      frame <= {mosi_sync[1], frame[49:1]};
      if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
    end
  end

  state_t state, state_nxt;
  logic   busy, frame_ok, chan_ok, is_freq, start, collide;
  logic [3:0] opcode, chan_f;

  assign busy     = (state != S_IDLE);
  assign opcode   = frame[3:0];
  assign chan_f   = frame[49:46];
  assign frame_ok = cs_rise && (bit_cnt == 6'd50);
  assign chan_ok  = ({28'd0, chan_f} < NUM_PLL);
  assign is_freq  = frame_ok && (opcode == 4'd2) && chan_ok;
  assign start    = is_freq && !busy;
  assign collide  = is_freq && busy;

  // ---------------- error flag, presets and LO outputs ----------------------
  logic       err;
  logic [7:0] p1_fs, p1_vc, p2_fs, p2_vc;

  // A rejected command on the same frame outranks the clear-on-read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err   <= 1'b0;
      p1_fs <= '0;
      p1_vc <= '0;
      p2_fs <= '0;
      p2_vc <= '0;
    end else begin
      if (collide)      err <= 1'b1;
      else if (cs_rise) err <= 1'b0;
      if (frame_ok && opcode == 4'd3) begin
        p1_fs <= frame[11:4];
        p1_vc <= frame[19:12];
      end
      if (frame_ok && opcode == 4'd4) begin
        p2_fs <= frame[11:4];
        p2_vc <= frame[19:12];
      end
    end
  end

  // Trigger 1 has priority when both edges land in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs    <= '0;
      vctrl <= '0;
    end else if (t1_rise) begin
      fs    <= p1_fs;
      vctrl <= p1_vc;
    end else if (t2_rise) begin
      fs    <= p2_fs;
      vctrl <= p2_vc;
    end
  end

  // ---------------- status readback -----------------------------------------
  logic [SW-1:0] status_sr, status_word;
  assign status_word = {err, busy, lock_s};

  // Snapshot at cs fall, then one bit per spi_clk fall; zeros shift in behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_miso  <= 1'b0;
      status_sr <= '0;
    end else if (cs_fall) begin
      spi_miso  <= status_word[0];
      status_sr <= status_word >> 1;
    end else if (!cs_low) begin
      spi_miso  <= 1'b0;
    end else if (sclk_fall) begin
      spi_miso  <= status_sr[0];
      status_sr <= status_sr >> 1;
    end
  end

  // ---------------- register write sequencer --------------------------------
  logic [CW-1:0] cnt;
  logic [4:0]    bit_idx;
  logic [31:0]   shreg, word_r1, word_r0;
  logic [3:0]    sel;
  logic          phase_r0;
  logic          ser_clk, ser_data, ser_le;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and serial-line decode.
  always_comb begin
    state_nxt = state;
    ser_clk   = 1'b0;
    ser_data  = 1'b0;
    ser_le    = 1'b0;
    case (state)
      S_IDLE:    if (start) state_nxt = S_LOAD_R1;
      S_LOAD_R1: state_nxt = S_SHIFT;
      S_LOAD_R0: state_nxt = S_SHIFT;
      S_SHIFT: begin
        ser_clk  = (cnt >= CNT_HALF);
        ser_data = shreg[31];
        if (cnt == CNT_LAST && bit_idx == 5'd31) state_nxt = S_LATCH;
      end
      S_LATCH: begin
        ser_le = 1'b1;
        if (cnt == CNT_LAST) state_nxt = S_GAP;
      end
      S_GAP:     if (cnt == CNT_LAST) state_nxt = phase_r0 ? S_IDLE : S_LOAD_R0;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Sequencer datapath: command latch, bit timing and the 32-bit shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      word_r1  <= '0;
      word_r0  <= '0;
      sel      <= '0;
      phase_r0 <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          word_r1  <= {4'b0, frame[28:16], 12'b0, 3'b001};
          word_r0  <= {frame[45], frame[44:41], frame[15:4], frame[40:29], 3'b000};
          sel      <= chan_f;
          phase_r0 <= 1'b0;
        end
        S_LOAD_R1, S_LOAD_R0: begin
          shreg    <= (state == S_LOAD_R1) ? word_r1 : word_r0;
          cnt      <= '0;
          bit_idx  <= '0;
          phase_r0 <= (state == S_LOAD_R0);
        end
        S_SHIFT: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            shreg   <= {shreg[30:0], 1'b0};
            bit_idx <= bit_idx + 5'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
      endcase
    end
  end

  logic [NUM_PLL-1:0] sel_mask;
  genvar g;
  generate
    for (g = 0; g < NUM_PLL; g++) begin : g_chan_sel
      assign sel_mask[g] = (sel == 4'(g));
    end
  endgenerate

  // Registered pin drivers so the synthesizer sees glitch-free lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adf4159_clk  <= '0;
      adf4159_data <= '0;
      adf4159_le   <= '0;
    end else begin
      adf4159_clk  <= ser_clk  ? sel_mask : '0;
      adf4159_data <= ser_data ? sel_mask : '0;
      adf4159_le   <= ser_le   ? sel_mask : '0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adf4159_ctrl_top.sv
`default_nettype none
// ============================================================================
// Module   : tb_adf4159_ctrl_top
// Brief    : Directed self-checking bench for adf4159_ctrl_top.
// Revision : 1.0  initial release
// ============================================================================
module tb_adf4159_ctrl_top;

  localparam int SPI_HALF = 4;   // spi_clk = clk/8
  localparam int SH       = 4;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       spi_clk = 1'b1, spi_cs = 1'b1, spi_mosi = 1'b0;
  logic       spi_miso;
  logic [5:0] adf4159_clk, adf4159_data, adf4159_le, pll_lock = '0;
  logic       freq_trig1 = 1'b0, freq_trig2 = 1'b0;
  logic [7:0] fs, vctrl;

  int total = 0, bad = 0;

  adf4159_ctrl_top #(.SCLK_HALF(SH), .NUM_PLL(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_clk(spi_clk), .spi_cs(spi_cs), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .adf4159_clk(adf4159_clk), .adf4159_data(adf4159_data), .adf4159_le(adf4159_le),
    .pll_lock(pll_lock), .freq_trig1(freq_trig1), .freq_trig2(freq_trig2),
    .fs(fs), .vctrl(vctrl)
  );

  always #5 clk = ~clk;

  // Pin monitor: collects 32-bit words per le pulse, tagged with channel.
  logic [31:0] mon_sr [6];
  logic [5:0]  prev_clk = '0, prev_le = '0, mon_mask = '0;
  logic [34:0] words[$];
  int          activity = 0, other_act = 0;

  always @(negedge clk) begin
    for (int c = 0; c < 6; c++) begin
      if (adf4159_clk[c] && !prev_clk[c]) mon_sr[c] = {mon_sr[c][30:0], adf4159_data[c]};
      if (adf4159_le[c] && !prev_le[c]) words.push_back({3'(c), mon_sr[c]});
    end
    if (|{adf4159_clk, adf4159_data, adf4159_le}) activity++;
    if (|((adf4159_clk | adf4159_data | adf4159_le) & ~mon_mask)) other_act++;
    prev_clk = adf4159_clk;
    prev_le  = adf4159_le;
  end

  function automatic logic [49:0] freq_frame(input logic [3:0] ch, input logic [3:0] op);
    return {ch, 1'b1, 4'b0100, 25'h1123456, 12'hCCC, op};
  endfunction

  function automatic logic [49:0] preset_frame(input logic [3:0] op, input logic [7:0] f,
                                               input logic [7:0] v);
    return {30'd0, v, f, op};
  endfunction

  task automatic spi_xfer(input logic [49:0] frm, input int nbits,
                          output logic [7:0] st, output logic after8);
    st = '0;
    after8 = 1'b0;
    @(negedge clk);
    spi_cs = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 8) st[i] = spi_miso;
      else if (i == 8) after8 = spi_miso;
      spi_clk  = 1'b0;
      spi_mosi = frm[i];
      repeat (SPI_HALF) @(negedge clk);
      spi_clk = 1'b1;
      repeat (SPI_HALF) @(negedge clk);
    end
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_words(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (words.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic pulse_trig(input bit t1, input bit t2);
    @(negedge clk);
    freq_trig1 = t1;
    freq_trig2 = t2;
    repeat (4) @(negedge clk);
    freq_trig1 = 1'b0;
    freq_trig2 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++; if (adf4159_clk !== 6'd0)  begin bad++; $display("FAIL reset_clk got=%b exp=0", adf4159_clk); end
    total++; if (adf4159_data !== 6'd0) begin bad++; $display("FAIL reset_data got=%b exp=0", adf4159_data); end
    total++; if (adf4159_le !== 6'd0)   begin bad++; $display("FAIL reset_le got=%b exp=0", adf4159_le); end
    total++; if (spi_miso !== 1'b0)     begin bad++; $display("FAIL reset_miso got=%b exp=0", spi_miso); end
    total++; if ({fs, vctrl} !== 16'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", {fs, vctrl}); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_write(input string nm, input logic [2:0] ch);
    bit ok;
    logic [34:0] w0, w1;
    wait_words(2, ok);
    total++; if (!ok || words.size() != 2) begin bad++; $display("FAIL %s_count got=%0d exp=2", nm, words.size()); end
    w0 = (words.size() > 0) ? words[0] : 'x;
    w1 = (words.size() > 1) ? words[1] : 'x;
    total++; if (w0 !== {ch, 32'h0A2B0001}) begin bad++; $display("FAIL %s_r1 got=%h exp=%h", nm, w0, {ch, 32'h0A2B0001}); end
    total++; if (w1 !== {ch, 32'hA6664488}) begin bad++; $display("FAIL %s_r0 got=%h exp=%h", nm, w1, {ch, 32'hA6664488}); end
    total++; if (other_act != 0) begin bad++; $display("FAIL %s_other_ch got=%0d exp=0", nm, other_act); end
  endtask

  task automatic test_freq_write();
    logic [7:0] st; logic a8;
    words.delete(); mon_mask = 6'b000010; other_act = 0;
    spi_xfer(freq_frame(4'd1, 4'd2), 50, st, a8);
    check_write("freq_ch1", 3'd1);
  endtask

  task automatic test_short_frame();
    logic [7:0] st; logic a8; int a0;
    a0 = activity;
    spi_xfer(freq_frame(4'd1, 4'd2), 49, st, a8);
    repeat (700) @(negedge clk);
    total++; if (activity != a0) begin bad++; $display("FAIL short_frame activity got=%0d exp=0", activity - a0); end
  endtask

  task automatic test_ignored();
    logic [7:0] st; logic a8; int a0;
    a0 = activity;
    spi_xfer(freq_frame(4'd7, 4'd2), 50, st, a8);
    spi_xfer(freq_frame(4'd1, 4'd5), 50, st, a8);
    repeat (700) @(negedge clk);
    total++; if (activity != a0) begin bad++; $display("FAIL ignored activity got=%0d exp=0", activity - a0); end
    spi_xfer(50'd0, 50, st, a8);
    total++; if (st[7:6] !== 2'b00) begin bad++; $display("FAIL ignored_err_busy got=%b exp=00", st[7:6]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] st; logic a8;
    words.delete(); mon_mask = 6'b000100; other_act = 0;
    spi_xfer(freq_frame(4'd2, 4'd2), 50, st, a8);
    spi_xfer(freq_frame(4'd3, 4'd2), 50, st, a8);
    total++; if (st[6] !== 1'b1) begin bad++; $display("FAIL b2b_busy_bit got=%b exp=1", st[6]); end
    check_write("b2b_ch2", 3'd2);
    spi_xfer(50'd0, 50, st, a8);
    total++; if (st[7] !== 1'b1) begin bad++; $display("FAIL b2b_err_set got=%b exp=1", st[7]); end
    spi_xfer(50'd0, 50, st, a8);
    total++; if (st[7] !== 1'b0) begin bad++; $display("FAIL b2b_err_clear got=%b exp=0", st[7]); end
  endtask

  task automatic test_presets();
    logic [7:0] st; logic a8;
    spi_xfer(preset_frame(4'd3, 8'h5A, 8'h33), 50, st, a8);
    total++; if ({fs, vctrl} !== 16'h0000) begin bad++; $display("FAIL preset_no_trig got=%h exp=0000", {fs, vctrl}); end
    pulse_trig(1'b1, 1'b0);
    total++; if ({fs, vctrl} !== 16'h5A33) begin bad++; $display("FAIL preset_trig1 got=%h exp=5a33", {fs, vctrl}); end
    spi_xfer(preset_frame(4'd4, 8'h11, 8'h22), 50, st, a8);
    pulse_trig(1'b1, 1'b1);
    total++; if ({fs, vctrl} !== 16'h5A33) begin bad++; $display("FAIL preset_both got=%h exp=5a33", {fs, vctrl}); end
    pulse_trig(1'b0, 1'b1);
    total++; if ({fs, vctrl} !== 16'h1122) begin bad++; $display("FAIL preset_trig2 got=%h exp=1122", {fs, vctrl}); end
  endtask

  task automatic test_status();
    logic [7:0] st, exp_st; logic a8;
    pll_lock = 6'b101010;
    repeat (4) @(negedge clk);
    exp_st = 8'b0010_1010;
    spi_xfer(50'd0, 50, st, a8);
    for (int i = 0; i < 8; i++) begin
      total++; if (st[i] !== exp_st[i]) begin bad++; $display("FAIL status_bit%0d got=%b exp=%b", i, st[i], exp_st[i]); end
    end
    total++; if (a8 !== 1'b0) begin bad++; $display("FAIL status_after8 got=%b exp=0", a8); end
    total++; if (spi_miso !== 1'b0) begin bad++; $display("FAIL status_cs_high got=%b exp=0", spi_miso); end
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] st; logic a8; int a0;
    words.delete(); mon_mask = 6'b010000; other_act = 0;
    a0 = activity;
    spi_xfer(freq_frame(4'd4, 4'd2), 50, st, a8);
    repeat (30) @(negedge clk);
    total++; if (activity == a0) begin bad++; $display("FAIL midrst_started got=0 exp=nonzero"); end
    rst_n = 1'b0;
    #1;
    total++; if ({adf4159_clk, adf4159_data, adf4159_le} !== 18'd0) begin
      bad++; $display("FAIL midrst_pins got=%h exp=0", {adf4159_clk, adf4159_data, adf4159_le}); end
    total++; if ({fs, vctrl} !== 16'd0) begin bad++; $display("FAIL midrst_lo got=%h exp=0", {fs, vctrl}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    words.delete(); other_act = 0;
    spi_xfer(freq_frame(4'd4, 4'd2), 50, st, a8);
    check_write("midrst_ch4", 3'd4);
  endtask

  initial begin
    test_reset();
    test_freq_write();
    test_short_frame();
    test_ignored();
    test_back_to_back();
    test_presets();
    test_status();
    test_reset_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
